// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package mdu_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 multiply / restoring divide on operand magnitudes; owns HI/LO.
// One 2*XLEN accumulator holds the product, or remainder:quotient for divides.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] data0_in,
  input  logic [XLEN-1:0] data1_in,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  state_e            state, state_nxt;
  logic [5:0]        cnt;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   opnd;      // multiplicand for MUL, divisor for DIV
  logic [XLEN-1:0]   a_raw;
  logic              div_zero, neg_res, neg_rem;
  logic [2*XLEN-1:0] acc, acc_step, prod_fix;
  logic [XLEN-1:0]   a_abs, b_abs, sub, q_fix, r_fix;
  logic [XLEN:0]     add_sum, rem_hi;
  logic              div_ge;

  assign busy  = (state != IDLE);
  assign a_abs = abs_x(data0_in, op[0]);
  assign b_abs = abs_x(data1_in, op[0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 6'(MDU_ITERS - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of either loop; the low half shifts out multiplier bits
  // or shifts in quotient bits.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_hi   = acc[2*XLEN-1:XLEN-1];
    div_ge   = (rem_hi >= {1'b0, opnd});
    sub      = rem_hi[XLEN-1:0] - opnd;
    acc_step = {add_sum, acc[XLEN-1:1]};
    if (op_q[1])
      acc_step = div_ge ? {sub, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    prod_fix = neg_d(acc, neg_res);
    q_fix    = neg_w(acc[XLEN-1:0], neg_res);
    r_fix    = neg_w(acc[2*XLEN-1:XLEN], neg_rem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= OP_MULTU;
      opnd     <= '0;
      a_raw    <= '0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi_out <= wdata_in;
          if (lo_we) lo_out <= wdata_in;
          if (start) begin
            op_q     <= op;
            cnt      <= '0;
            a_raw    <= data0_in;
            div_zero <= (data1_in == '0);
            neg_res  <= op[0] & (data0_in[XLEN-1] ^ data1_in[XLEN-1]);
            neg_rem  <= op[0] & data0_in[XLEN-1];
            opnd     <= op[1] ? b_abs : a_abs;
            acc      <= {{XLEN{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          done <= 1'b1;
          if (!op_q[1]) begin
            {hi_out, lo_out} <= prod_fix;
          end else if (div_zero) begin
            hi_out <= a_raw;
            lo_out <= '1;
          end else begin
            hi_out <= r_fix;
            lo_out <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data0_in, data1_in, wdata_in;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data0_in(data0_in), .data1_in(data1_in),
    .hi_we(hi_we), .lo_we(lo_we), .wdata_in(wdata_in),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issue one op and sample at E32 (still busy) and E33+ (done cycle).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                        output logic [31:0] h, l, output logic mid_ok, fin_ok);
    @(negedge clk);
    start = 1'b1; op = o; data0_in = a; data1_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    mid_ok = (busy === 1'b1) && (done === 1'b0);
    @(posedge clk); #1;
    fin_ok = (done === 1'b1) && (busy === 1'b0);
    h = hi_out;
    l = lo_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; data0_in = '0; data1_in = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi_out, lo_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t v [10];
    logic [31:0] h, l;
    logic mid_ok, fin_ok;
    v[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    v[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
    v[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    v[3] = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0"};
    v[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    v[5] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_neg"};
    v[6] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7"};
    v[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
    v[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7dm2"};
    v[9] = '{2'b00, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         "multu_carry"};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, h, l, mid_ok, fin_ok);
      checks++;
      if (h !== v[i].hi) begin
        errors++;
        $display("FAIL %s hi: got %h expected %h", v[i].name, h, v[i].hi);
      end
      checks++;
      if (l !== v[i].lo) begin
        errors++;
        $display("FAIL %s lo: got %h expected %h", v[i].name, l, v[i].lo);
      end
      checks++;
      if ({mid_ok, fin_ok} !== 2'b11) begin
        errors++;
        $display("FAIL %s timing: mid/fin=%b expected 11", v[i].name, {mid_ok, fin_ok});
      end
    end
  endtask

  task automatic test_start_ignored();
    // IDLE write lands next cycle
    @(negedge clk);
    hi_we = 1'b1; wdata_in = 32'h0000_AAAA;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi_out !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL idle_hi_we: got %h expected %h", hi_out, 32'h0000_AAAA);
    end
    // MULTU 5x5, then a second start plus hi_we at cycle 10
    @(negedge clk);
    start = 1'b1; op = 2'b00; data0_in = 32'd5; data1_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b10; data0_in = 32'd100; data1_in = 32'd3;
    hi_we = 1'b1; wdata_in = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi_out !== 32'h0000_AAAA || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hi_we: hi=%h busy=%b expected hi=0000aaaa busy=1", hi_out, busy);
    end
    repeat (21) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_mid: busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, hi_out, lo_out} !== {2'b10, 32'd0, 32'd25}) begin
      errors++;
      $display("FAIL ignore_result: done=%b busy=%b hi=%h lo=%h expected 1 0 0 19", done, busy, hi_out, lo_out);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b expected 0 0", done, busy);
    end
    @(negedge clk);
    hi_we = 1'b1; wdata_in = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi_out !== 32'h0000_1234 || lo_out !== 32'd25) begin
      errors++;
      $display("FAIL idle_write: hi=%h lo=%h expected 00001234 00000019", hi_out, lo_out);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    logic [31:0] h, l;
    logic mid_ok, fin_ok;
    @(negedge clk);
    start = 1'b1; op = 2'b10; data0_in = 32'd1000; data1_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi_out, lo_out);
    end
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: activity=%b expected 0", saw_done);
    end
    run_op(2'b00, 32'd6, 32'd7, h, l, mid_ok, fin_ok);
    checks++;
    if ({h, l} !== {32'd0, 32'd42} || {mid_ok, fin_ok} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_mul: hi=%h lo=%h timing=%b expected 0 2a 11", h, l, {mid_ok, fin_ok});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    logic mid_ok, fin_ok;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, h, l, mid_ok, fin_ok);
    checks++;
    if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB} || fin_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: hi=%h lo=%h fin=%b expected ffffffff ffffffeb 1", h, l, fin_ok);
    end
    // next start is driven inside the done cycle
    run_op(2'b10, 32'd100, 32'd7, h, l, mid_ok, fin_ok);
    checks++;
    if ({h, l} !== {32'd2, 32'd14} || {mid_ok, fin_ok} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_second: hi=%h lo=%h timing=%b expected 2 e 11", h, l, {mid_ok, fin_ok});
    end
    // hi_we on the same edge as start lands, then the op overwrites it
    @(negedge clk);
    start = 1'b1; op = 2'b00; data0_in = 32'd3; data1_in = 32'd3;
    hi_we = 1'b1; wdata_in = 32'h0000_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi_out !== 32'h0000_BEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_we: hi=%h busy=%b expected 0000beef 1", hi_out, busy);
    end
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if ({done, hi_out, lo_out} !== {1'b1, 32'd0, 32'd9}) begin
      errors++;
      $display("FAIL start_we_commit: done=%b hi=%h lo=%h expected 1 0 9", done, hi_out, lo_out);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
